// File: rtl/watchdog_multi.sv
`default_nettype none
// ============================================================================
//  Module   : watchdog_multi
//  Brief    : NUM_CH independent heartbeat watchdogs. Each channel warns after
//             WARN_CYC silent cycles and trips (sticky) after TIMEOUT_CYC.
//             Any trip event fires a RST_PULSE-cycle force_reset pulse and
//             latches the lowest tripping channel index into fault_chan.
//  Options  : WD_WINDOW_EN - when defined, a kick arriving while the counter
//             is below WIN_MIN is treated as a fault and trips the channel.
//  Revision : 1.0 - initial release
// ============================================================================
module watchdog_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1000,
  parameter int WARN_CYC    = 750,
  parameter int WIN_MIN     = 100,
  parameter int RST_PULSE   = 16
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic [NUM_CH-1:0]                             enable,
  input  logic [NUM_CH-1:0]                             heartbeat,
  input  logic [NUM_CH-1:0]                             clear,
  output logic [NUM_CH-1:0]                             warning,
  output logic [NUM_CH-1:0]                             triggered,
  output logic [NUM_CH-1:0]                             early_fault,
  output logic                                          force_reset,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fault_chan
);

  localparam int c_fc_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_pw   = $clog2(RST_PULSE + 1);

  // Per-channel state encoding
  localparam logic [1:0] c_st_disabled = 2'd0;
  localparam logic [1:0] c_st_run      = 2'd1;
  localparam logic [1:0] c_st_warn     = 2'd2;
  localparam logic [1:0] c_st_tripped  = 2'd3;

  // Thresholds are compared against the count held before the edge, so the
  // N-th silent edge is the one that sees a count of N-1.
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_warn_m1    = CNT_W'(WARN_CYC - 1);
  localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [c_pw-1:0]  c_pulse_load = c_pw'(RST_PULSE - 1);

`ifdef WD_WINDOW_EN
  localparam logic [CNT_W-1:0] c_win_min = CNT_W'(WIN_MIN);
`endif

  logic [NUM_CH-1:0] w_trip;
  logic              w_trip_evt;
  logic [c_fc_w-1:0] w_low_idx;
  logic [c_pw-1:0]   r_pulse_cnt;
  logic              r_force;
  logic [c_fc_w-1:0] r_fault_chan;

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [1:0]       r_state;
    logic [1:0]       w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_trip_ch;
    logic             w_early_trip;
    logic             r_warn;
    logic             r_trig;

`ifdef WD_WINDOW_EN
    // A kick that arrives too soon after the previous one (or after enable)
    assign w_early_trip = (r_state == c_st_run) && enable[gi] && heartbeat[gi]
                          && !clear[gi] && (r_cnt < c_win_min);
`else
    assign w_early_trip = 1'b0;
`endif

    // Next-state and counter rules for one channel
    always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_trip_ch   = 1'b0;
      case (r_state)
        c_st_disabled: begin
          w_nxt_cnt = '0;
          if (enable[gi]) w_nxt_state = c_st_run;
        end
        c_st_run, c_st_warn: begin
          if (!enable[gi]) begin
            w_nxt_state = c_st_disabled;
            w_nxt_cnt   = '0;
          end else if (heartbeat[gi]) begin
            if (w_early_trip) begin
              w_nxt_state = c_st_tripped;
              w_trip_ch   = 1'b1;
            end else begin
              w_nxt_state = c_st_run;
              w_nxt_cnt   = '0;
            end
          end else if (r_cnt >= c_timeout_m1) begin
            // A coincident clear suppresses the trip; the count then holds
            // at the threshold so the channel trips once clear drops.
            if (!clear[gi]) begin
              w_nxt_state = c_st_tripped;
              w_nxt_cnt   = r_cnt + c_one;
              w_trip_ch   = 1'b1;
            end
          end else begin
            w_nxt_cnt = r_cnt + c_one;
            if (r_cnt >= c_warn_m1) w_nxt_state = c_st_warn;
          end
        end
        c_st_tripped: begin
          if (clear[gi]) begin
            w_nxt_state = c_st_disabled;
            w_nxt_cnt   = '0;
          end
        end
        default: begin
          w_nxt_state = c_st_disabled;
          w_nxt_cnt   = '0;
        end
      endcase
    end

    // Channel state, counter and registered status flags
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_state <= c_st_disabled;
        r_cnt   <= '0;
        r_warn  <= 1'b0;
        r_trig  <= 1'b0;
      end else begin
        r_state <= w_nxt_state;
        r_cnt   <= w_nxt_cnt;
        r_warn  <= (w_nxt_state == c_st_warn);
        r_trig  <= (w_nxt_state == c_st_tripped);
      end
    end

`ifdef WD_WINDOW_EN
    logic r_early;
    // Early-kick cause flag, alive exactly as long as the channel is tripped
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_early <= 1'b0;
      end else if (w_nxt_state != c_st_tripped) begin
        r_early <= 1'b0;
      end else if (w_early_trip) begin
        r_early <= 1'b1;
      end
    end
    assign early_fault[gi] = r_early;
`else
    assign early_fault[gi] = 1'b0;
`endif

    assign w_trip[gi]    = w_trip_ch;
    assign warning[gi]   = r_warn;
    assign triggered[gi] = r_trig;
  end

  assign w_trip_evt = |w_trip;

  // Lowest index among channels tripping on this edge
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_trip[i]) w_low_idx = c_fc_w'(i);
    end
  end

  // Reset pulse generator; every trip event reloads the full length
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pulse_cnt  <= '0;
      r_force      <= 1'b0;
      r_fault_chan <= '0;
    end else if (w_trip_evt) begin
      r_pulse_cnt  <= c_pulse_load;
      r_force      <= 1'b1;
      r_fault_chan <= w_low_idx;
    end else if (r_pulse_cnt != '0) begin
      r_pulse_cnt <= r_pulse_cnt - c_pw'(1);
    end else begin
      r_force <= 1'b0;
    end
  end

  assign force_reset = r_force;
  assign fault_chan  = r_fault_chan;

endmodule
`default_nettype wire

// File: tb/tb_watchdog_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_watchdog_multi
//  Brief    : Directed and randomized bench for watchdog_multi, compared
//             against a silence-counting reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_watchdog_multi;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 32;
  localparam int TIMEOUT_CYC = 20;
  localparam int WARN_CYC    = 15;
  localparam int WIN_MIN     = 4;
  localparam int RST_PULSE   = 3;
`ifdef WD_WINDOW_EN
  localparam bit c_win = 1'b1;
`else
  localparam bit c_win = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NUM_CH-1:0] enable = '0;
  logic [NUM_CH-1:0] heartbeat = '0;
  logic [NUM_CH-1:0] clear = '0;
  logic [NUM_CH-1:0] warning;
  logic [NUM_CH-1:0] triggered;
  logic [NUM_CH-1:0] early_fault;
  logic              force_reset;
  logic [1:0]        fault_chan;

  always #5 clk = ~clk;

  watchdog_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC),
    .WARN_CYC(WARN_CYC), .WIN_MIN(WIN_MIN), .RST_PULSE(RST_PULSE)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .heartbeat(heartbeat),
    .clear(clear), .warning(warning), .triggered(triggered),
    .early_fault(early_fault), .force_reset(force_reset),
    .fault_chan(fault_chan)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: silence length per channel, trip flags, pulse time left
  bit m_act   [NUM_CH];
  bit m_trip  [NUM_CH];
  bit m_early [NUM_CH];
  int m_silent[NUM_CH];
  int m_pulse;
  int m_fault;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = 0; m_trip[c] = 0; m_early[c] = 0; m_silent[c] = 0;
    end
    m_pulse = 0;
    m_fault = 0;
  endfunction

  function automatic void model_edge(logic [NUM_CH-1:0] en, logic [NUM_CH-1:0] hb,
                                     logic [NUM_CH-1:0] clr);
    int lowest;
    bit trips;
    lowest = -1;
    for (int c = 0; c < NUM_CH; c++) begin
      trips = 1'b0;
      if (m_trip[c]) begin
        if (clr[c]) begin
          m_trip[c] = 0; m_early[c] = 0; m_act[c] = 0; m_silent[c] = 0;
        end
      end else if (!m_act[c]) begin
        m_act[c] = en[c];
        m_silent[c] = 0;
      end else if (!en[c]) begin
        m_act[c] = 0;
        m_silent[c] = 0;
      end else if (hb[c]) begin
        if (c_win && m_silent[c] < WIN_MIN && !clr[c]) begin
          trips = 1'b1;
          m_early[c] = 1;
        end else begin
          m_silent[c] = 0;
        end
      end else if (m_silent[c] + 1 >= TIMEOUT_CYC) begin
        if (!clr[c]) trips = 1'b1;
      end else begin
        m_silent[c]++;
      end
      if (trips) begin
        m_trip[c] = 1;
        m_act[c] = 0;
        if (lowest < 0) lowest = c;
      end
    end
    if (lowest >= 0) begin
      m_pulse = RST_PULSE;
      m_fault = lowest;
    end else if (m_pulse > 0) begin
      m_pulse--;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NUM_CH-1:0] ew, et, ee;
    for (int c = 0; c < NUM_CH; c++) begin
      ew[c] = m_act[c] && !m_trip[c] && (m_silent[c] >= WARN_CYC);
      et[c] = m_trip[c];
      ee[c] = m_early[c];
    end
    check({tag, " warning"},     32'(warning),     32'(ew));
    check({tag, " triggered"},   32'(triggered),   32'(et));
    check({tag, " early_fault"}, 32'(early_fault), 32'(ee));
    check({tag, " force_reset"}, 32'(force_reset), 32'(m_pulse > 0));
    check({tag, " fault_chan"},  32'(fault_chan),  32'(m_fault));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " warning0"},   32'(warning),     32'(0));
    check({tag, " triggered0"}, 32'(triggered),   32'(0));
    check({tag, " early0"},     32'(early_fault), 32'(0));
    check({tag, " force0"},     32'(force_reset), 32'(0));
    check({tag, " fchan0"},     32'(fault_chan),  32'(0));
  endtask

  // One clock edge with the given inputs, then model update and compare
  task automatic step(input string tag, input logic [NUM_CH-1:0] en,
                      input logic [NUM_CH-1:0] hb, input logic [NUM_CH-1:0] clr);
    enable = en; heartbeat = hb; clear = clr;
    @(posedge clk);
    model_edge(en, hb, clr);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    enable = '0; heartbeat = '0; clear = '0;
    rstn = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    model_reset();
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1'b1;

    // Ch0 silent: warn at edge 15, trip at 20, 3-cycle pulse, fault_chan 0
    step("t21", 4'b0001, 4'b0000, 4'b0000);
    for (int k = 1; k <= 25; k++) begin
      step("t21", 4'b0001, 4'b0000, 4'b0000);
      check("t21 warn0",  32'(warning[0]),   32'(k >= 15 && k < 20));
      check("t21 trig0",  32'(triggered[0]), 32'(k >= 20));
      check("t21 force",  32'(force_reset),  32'(k >= 20 && k < 23));
    end
    check("t21 fault_chan", 32'(fault_chan), 32'(0));

    // Clear releases the trip; re-enable trips again 20 edges later
    step("t24clr", 4'b0000, 4'b0000, 4'b0001);
    check("t24 trig cleared", 32'(triggered[0]), 32'(0));
    step("t24", 4'b0001, 4'b0000, 4'b0000);
    for (int k = 1; k <= 20; k++) begin
      step("t24", 4'b0001, 4'b0000, 4'b0000);
      check("t24 retrip", 32'(triggered[0]), 32'(k == 20));
    end
    // Kick on edge 19 prevents the trip; clear on the trip edge also wins
    step("t24clr2", 4'b0000, 4'b0000, 4'b0001);
    step("t24b", 4'b0001, 4'b0000, 4'b0000);
    for (int k = 1; k <= 21; k++) begin
      step("t24b", 4'b0001, (k == 19) ? 4'b0001 : 4'b0000, 4'b0000);
      check("t24 kick19", 32'(triggered[0]), 32'(0));
    end
    for (int j = 3; j <= 20; j++) begin
      step("t12", 4'b0001, 4'b0000, (j == 20) ? 4'b0001 : 4'b0000);
    end
    check("t12 clear wins", 32'(triggered[0]), 32'(0));
    step("t12", 4'b0001, 4'b0000, 4'b0000);
    check("t12 trip after", 32'(triggered[0]), 32'(1));

    // Ch1 kicked every 10 cycles: never warns or trips
    do_reset();
    step("t22", 4'b0010, 4'b0000, 4'b0000);
    for (int k = 1; k <= 200; k++) begin
      step("t22", 4'b0010, (k % 10 == 0) ? 4'b0010 : 4'b0000, 4'b0000);
    end
    check("t22 warn",  32'(warning),     32'(0));
    check("t22 trig",  32'(triggered),   32'(0));
    check("t22 force", 32'(force_reset), 32'(0));

    // Ch2+ch3 trip together, ch1 one edge later: pulse restarts
    do_reset();
    step("t23", 4'b1100, 4'b0000, 4'b0000);
    step("t23", 4'b1110, 4'b0000, 4'b0000);
    for (int k = 2; k <= 26; k++) begin
      step("t23", 4'b1110, 4'b0000, 4'b0000);
      if (k == 20) check("t23 fc first", 32'(fault_chan), 32'(2));
      if (k == 21) check("t23 fc second", 32'(fault_chan), 32'(1));
      check("t23 force", 32'(force_reset), 32'(k >= 20 && k <= 23));
    end

    // Kick at count 2: trips only in windowed mode
    do_reset();
    step("t25", 4'b0001, 4'b0000, 4'b0000);
    step("t25", 4'b0001, 4'b0000, 4'b0000);
    step("t25", 4'b0001, 4'b0000, 4'b0000);
    step("t25", 4'b0001, 4'b0001, 4'b0000);
    check("t25 trig",  32'(triggered[0]),   32'(c_win));
    check("t25 early", 32'(early_fault[0]), 32'(c_win));
    for (int k = 0; k < 5; k++) step("t25", 4'b0001, 4'b0000, 4'b0000);

    // Reset during the pulse with ch0 in WARN, then restart from zero
    do_reset();
    step("t26", 4'b0010, 4'b0000, 4'b0000);
    for (int k = 1; k <= 21; k++) begin
      step("t26", (k >= 3) ? 4'b0011 : 4'b0010, 4'b0000, 4'b0000);
    end
    check("t26 warn0 pre",  32'(warning[0]),  32'(1));
    check("t26 force pre",  32'(force_reset), 32'(1));
    #2;
    rstn = 1'b0;
    #1;
    check_zero("t26 midreset");
    @(posedge clk);
    #1;
    model_reset();
    rstn = 1'b1;
    step("t26r", 4'b0001, 4'b0000, 4'b0000);
    for (int k = 1; k <= 15; k++) begin
      step("t26r", 4'b0001, 4'b0000, 4'b0000);
      check("t26 restart warn", 32'(warning[0]), 32'(k == 15));
    end

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [NUM_CH-1:0] en, hb, clr;
      for (int c = 0; c < NUM_CH; c++) begin
        en[c]  = ($urandom_range(0, 39) != 0);
        hb[c]  = ($urandom_range(0, 5 + 5 * c) == 0);
        clr[c] = ($urandom_range(0, 24) == 0);
      end
      step("rand", en, hb, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/watchdog_multi.md
WATCHDOG_MULTI -- requirements
Module: watchdog_multi

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_CH, 4, number of independent watchdog channels (1..16).
- CNT_W, 32, per-channel counter width.
- TIMEOUT_CYC, 1000, silent cycles before a channel trips.
- WARN_CYC, 750, silent cycles before a channel warns; must be less than TIMEOUT_CYC.
- WIN_MIN, 100, minimum legal heartbeat spacing (window mode only).
- RST_PULSE, 16, force_reset pulse length in cycles.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- rstn, in, 1, asynchronous active-low reset.
- enable, in, NUM_CH, per-channel enable.
- heartbeat, in, NUM_CH, per-channel kick (1-cycle, synchronous).
- clear, in, NUM_CH, per-channel release of tripped state.
- warning, out, NUM_CH, channel silent for at least WARN_CYC cycles.
- triggered, out, NUM_CH, channel tripped (sticky).
- early_fault, out, NUM_CH, channel tripped by an early kick.
- force_reset, out, 1, system reset pulse.
- fault_chan, out, clog2(NUM_CH) (min 1), lowest index of the latest trip event.

REQ-003 All outputs SHALL be registered; no combinational input-to-output path.

Function
REQ-004 Each channel SHALL run a state machine with states DISABLED, RUN, WARN and TRIPPED, plus a CNT_W-bit counter.
REQ-005 DISABLED: counter holds 0. enable=1 moves the channel to RUN on the next edge.
REQ-006 RUN and WARN: enable=0 SHALL go to DISABLED with the counter cleared.
REQ-007 RUN and WARN: heartbeat=1 SHALL clear the counter and go to RUN; otherwise the counter increments by 1.
REQ-008 warning[i] SHALL rise on the WARN_CYC-th consecutive enabled edge without a heartbeat (RUN to WARN).
REQ-009 triggered[i] SHALL rise on the TIMEOUT_CYC-th consecutive enabled edge without a heartbeat (WARN to TRIPPED).
REQ-010 If heartbeat coincides with the warn or timeout threshold edge, heartbeat SHALL win.
REQ-011 TRIPPED SHALL be sticky regardless of enable and heartbeat.
- Counter frozen; triggered=1; warning=0.
- Left only via clear[i]=1, which goes to DISABLED with counter 0 and early_fault[i] cleared.
REQ-012 clear[i] in RUN, WARN or DISABLED SHALL have no effect. A clear coincident with a trip edge SHALL win, so the channel does not trip.
REQ-013 A trip event is any edge where one or more channels enter TRIPPED. On each trip event:
- force_reset SHALL assert on the following cycle and stay high for exactly RST_PULSE cycles.
- A new trip event during the pulse SHALL restart the full RST_PULSE count.
REQ-014 On each trip event, fault_chan SHALL latch the lowest index among the channels tripping on that edge, and hold otherwise.
REQ-015 Channels SHALL be fully independent; simultaneous trips on several channels are one trip event.
REQ-016 Counter width SHALL be sufficient for TIMEOUT_CYC; no wrap-around is reachable because the counter freezes in TRIPPED.

Reset
REQ-017 rstn=0 SHALL asynchronously force:
- all channels to DISABLED with counter 0;
- warning=0, triggered=0, early_fault=0, force_reset=0, fault_chan=0;
- the pulse counter to 0.
REQ-018 Reset SHALL be released synchronously; the first active edge after release evaluates enable.
REQ-019 Reset mid-pulse SHALL terminate force_reset immediately.

Configuration
REQ-020 Macro WD_WINDOW_EN SHALL control windowed mode.
- Defined: a heartbeat in RUN with counter < WIN_MIN SHALL go to TRIPPED, set early_fault[i], and count as a trip event. This applies to the first kick after enable too.
- Undefined: heartbeats are accepted at any count; early_fault is tied 0; no window logic is synthesised.

Verification
(Bench parameters: NUM_CH=4, TIMEOUT_CYC=20, WARN_CYC=15, WIN_MIN=4, RST_PULSE=3.)
REQ-021 Ch0 enabled, no kicks -> warning[0] rises at edge 15, triggered[0] at edge 20, force_reset high for 3 cycles, fault_chan=0.
REQ-022 Ch1 kicked every 10 cycles for 200 cycles -> warning, triggered and force_reset all stay 0.
REQ-023 Ch2 and ch3 time out on the same edge -> one 3-cycle pulse, fault_chan=2. Ch1 trips 1 cycle into that pulse -> pulse extends to 3 cycles after ch1's trip, fault_chan=1.
REQ-024 Ch0 tripped, then clear[0] pulsed -> triggered[0]=0 next cycle, and ch0 re-trips 20 edges after re-enable. Kick on edge 19 -> no trip (REQ-010).
REQ-025 With WD_WINDOW_EN, ch0 kicked at count 2 -> triggered[0]=1 and early_fault[0]=1. Without the macro the same stimulus -> no trip.
REQ-026 rstn pulled low mid force_reset pulse and during WARN -> all outputs 0 immediately; the channel restarts from count 0 after release.
